// File: rtl/wbu_fifo_arb.sv
// Two-requester arbiter feeding a downstream FIFO: A sends multi-word packets, B single words.
// Occupancy is tracked locally so no word is ever written into a full FIFO.
module wbu_fifo_arb #(
  parameter int BW     = 36,
  parameter int LGFLEN = 10
) (
  input  logic          i_clk,
  input  logic          i_reset,
  input  logic          i_a_stb,
  input  logic [BW-1:0] i_a_data,
  input  logic          i_a_last,
  output logic          o_a_busy,
  input  logic          i_b_stb,
  input  logic [BW-1:0] i_b_data,
  output logic          o_b_busy,
  output logic          o_fifo_wr,
  output logic [BW-1:0] o_fifo_data,
  input  logic          i_fifo_rd,
  input  logic          i_fifo_empty_n,
  output logic          o_err
);
  localparam logic [LGFLEN:0] FLEN    = {1'b1, {LGFLEN{1'b0}}};
  localparam logic [LGFLEN:0] CNT_ONE = {{LGFLEN{1'b0}}, 1'b1};

  typedef enum logic [1:0] {IDLE, GNT_A, GNT_B} state_t;

  state_t          state_q, state_d;
  logic            last_b_q, last_b_d;  // 1 when B held the most recent grant
  logic [LGFLEN:0] r_count_q, r_count_d;
  logic            fifo_wr_q, fifo_wr_d;
  logic [BW-1:0]   fifo_data_q, fifo_data_d;
  logic            err_q, err_d;

  logic space, a_acc, b_acc, wr_acc, rd_acc;

  assign space    = (r_count_q < FLEN);
  assign o_a_busy = !((state_q == GNT_A) && space);
  assign o_b_busy = !((state_q == GNT_B) && space);
  assign a_acc    = i_a_stb && !o_a_busy;
  assign b_acc    = i_b_stb && !o_b_busy;
  assign wr_acc   = a_acc || b_acc;
  assign rd_acc   = i_fifo_rd && i_fifo_empty_n;

  assign o_fifo_wr   = fifo_wr_q;
  assign o_fifo_data = fifo_data_q;
  assign o_err       = err_q;

  always_comb begin
    state_d  = state_q;
    last_b_d = last_b_q;
    case (state_q)
      IDLE: begin
        if (i_a_stb && (!i_b_stb || last_b_q)) state_d = GNT_A;
        else if (i_b_stb)                      state_d = GNT_B;
      end
      GNT_A: begin
        // A keeps the grant until its last word goes through, even across stb gaps
        if (a_acc && i_a_last) begin
          state_d  = IDLE;
          last_b_d = 1'b0;
        end
      end
      GNT_B: begin
        if (b_acc) begin
          state_d  = IDLE;
          last_b_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    r_count_d   = r_count_q;
    fifo_wr_d   = wr_acc;
    fifo_data_d = fifo_data_q;
    err_d       = err_q;
    if (a_acc)      fifo_data_d = i_a_data;
    else if (b_acc) fifo_data_d = i_b_data;
    if (wr_acc && !rd_acc)
      r_count_d = r_count_q + CNT_ONE;
    else if (!wr_acc && rd_acc && (r_count_q != '0))
      r_count_d = r_count_q - CNT_ONE;
    // A qualified read against an empty count means the FIFO and our model disagree
    if (rd_acc && (r_count_q == '0)) err_d = 1'b1;
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q     <= IDLE;
      last_b_q    <= 1'b1;
      r_count_q   <= '0;
      fifo_wr_q   <= 1'b0;
      fifo_data_q <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      last_b_q    <= last_b_d;
      r_count_q   <= r_count_d;
      fifo_wr_q   <= fifo_wr_d;
      fifo_data_q <= fifo_data_d;
      err_q       <= err_d;
    end
  end
endmodule

// File: tb/tb_wbu_fifo_arb.sv
// Bench for wbu_fifo_arb with a 4-deep FIFO: scoreboarded write data plus
// cycle-exact acceptance, busy and error checks for arbitration scenarios.
module tb_wbu_fifo_arb;
  localparam int BW     = 36;
  localparam int LGFLEN = 2;

  logic          i_clk = 1'b0;
  logic          i_reset = 1'b0;
  logic          i_a_stb = 1'b0;
  logic [BW-1:0] i_a_data = '0;
  logic          i_a_last = 1'b0;
  logic          o_a_busy;
  logic          i_b_stb = 1'b0;
  logic [BW-1:0] i_b_data = '0;
  logic          o_b_busy;
  logic          o_fifo_wr;
  logic [BW-1:0] o_fifo_data;
  logic          i_fifo_rd = 1'b0;
  logic          i_fifo_empty_n = 1'b0;
  logic          o_err;

  wbu_fifo_arb #(.BW(BW), .LGFLEN(LGFLEN)) dut (
    .i_clk(i_clk), .i_reset(i_reset),
    .i_a_stb(i_a_stb), .i_a_data(i_a_data), .i_a_last(i_a_last), .o_a_busy(o_a_busy),
    .i_b_stb(i_b_stb), .i_b_data(i_b_data), .o_b_busy(o_b_busy),
    .o_fifo_wr(o_fifo_wr), .o_fifo_data(o_fifo_data),
    .i_fifo_rd(i_fifo_rd), .i_fifo_empty_n(i_fifo_empty_n), .o_err(o_err)
  );

  always #5 i_clk = ~i_clk;

  typedef struct packed {
    logic          last;
    logic [BW-1:0] data;
  } aword_t;

  aword_t        a_q[$];
  logic [BW-1:0] b_q[$];
  logic [BW-1:0] sb[$];
  int            a_acc_cyc[$], b_acc_cyc[$], wr_cyc[$];
  logic          a_busy_log[64], b_busy_log[64], err_log[64];
  logic [63:0]   a_gap_mask = '0, rd_mask = '0;
  int            cyc = 0;
  int            vectors = 0, miscompares = 0;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_cycles(input string tag, input int got[$], input int n,
                              input int e0, input int e1, input int e2, input int e3, input int e4);
    int ex[5];
    ex = '{e0, e1, e2, e3, e4};
    check_val({tag, "_count"}, 64'(got.size()), 64'(n));
    for (int i = 0; i < n && i < got.size(); i++)
      check_val($sformatf("%s_cyc%0d", tag, i), 64'(got[i]), 64'(ex[i]));
  endtask

  // Monitor: retire writes against the scoreboard, then record this cycle's handshakes
  always @(negedge i_clk) begin
    logic [BW-1:0] exp_d;
    if (!i_reset) begin
      if (o_fifo_wr) begin
        wr_cyc.push_back(cyc);
        if (sb.size() == 0) check_val("unexpected_wr", 64'd1, 64'd0);
        else begin
          exp_d = sb.pop_front();
          check_val("fifo_data", 64'(o_fifo_data), 64'(exp_d));
        end
      end
      if (cyc < 64) begin
        a_busy_log[cyc] = o_a_busy;
        b_busy_log[cyc] = o_b_busy;
        err_log[cyc]    = o_err;
      end
      if (i_a_stb && !o_a_busy) begin
        sb.push_back(a_q[0].data);
        void'(a_q.pop_front());
        a_acc_cyc.push_back(cyc);
      end
      if (i_b_stb && !o_b_busy) begin
        sb.push_back(b_q[0]);
        void'(b_q.pop_front());
        b_acc_cyc.push_back(cyc);
      end
    end
  end

  task automatic run(input int n);
    repeat (n) begin
      @(posedge i_clk);
      #1;
      cyc++;
      i_a_stb        = (a_q.size() != 0) && !a_gap_mask[cyc];
      i_a_data       = (a_q.size() != 0) ? a_q[0].data : '0;
      i_a_last       = (a_q.size() != 0) ? a_q[0].last : 1'b0;
      i_b_stb        = (b_q.size() != 0);
      i_b_data       = (b_q.size() != 0) ? b_q[0] : '0;
      i_fifo_rd      = rd_mask[cyc];
      i_fifo_empty_n = rd_mask[cyc];
    end
  endtask

  // Called away from clock edges; leaves cyc=0 with the DUT idle just after a posedge
  task automatic pulse_reset(input string tag);
    i_a_stb = 1'b0; i_b_stb = 1'b0; i_fifo_rd = 1'b0; i_fifo_empty_n = 1'b0;
    i_reset = 1'b1;
    #1;
    check_val({tag, "_a_busy"}, 64'(o_a_busy), 64'd1);
    check_val({tag, "_b_busy"}, 64'(o_b_busy), 64'd1);
    check_val({tag, "_wr"}, 64'(o_fifo_wr), 64'd0);
    check_val({tag, "_data"}, 64'(o_fifo_data), 64'd0);
    check_val({tag, "_err"}, 64'(o_err), 64'd0);
    @(posedge i_clk);
    #1;
    i_reset = 1'b0;
    sb.delete(); a_acc_cyc.delete(); b_acc_cyc.delete(); wr_cyc.delete();
    foreach (a_busy_log[i]) begin
      a_busy_log[i] = 1'bx; b_busy_log[i] = 1'bx; err_log[i] = 1'bx;
    end
    a_gap_mask = '0; rd_mask = '0; cyc = 0;
  endtask

  task automatic end_scen(input string tag);
    @(negedge i_clk);
    #2;
    check_val({tag, "_sb_drained"}, 64'(sb.size()), 64'd0);
  endtask

  task automatic load_a(input int n, input logic [BW-1:0] base);
    for (int i = 0; i < n; i++) a_q.push_back('{last: (i == n - 1), data: base + BW'(i)});
  endtask

  initial begin
    #2;
    pulse_reset("rst0");

    // Both requesters pending out of reset: A packet first, then the B word
    a_q.delete(); b_q.delete();
    load_a(3, 36'hA_0000_0010);
    b_q.push_back(36'hB_0000_00B0);
    run(10);
    end_scen("s1");
    check_val("s1_idle_a_busy", 64'(a_busy_log[1]), 64'd1);
    check_val("s1_idle_b_busy", 64'(b_busy_log[1]), 64'd1);
    check_val("s1_gnt_a_busy", 64'(a_busy_log[2]), 64'd0);
    check_val("s1_gnt_a_b_busy", 64'(b_busy_log[2]), 64'd1);
    check_cycles("s1_a_acc", a_acc_cyc, 3, 2, 3, 4, 0, 0);
    check_cycles("s1_b_acc", b_acc_cyc, 1, 6, 0, 0, 0, 0);
    check_cycles("s1_wr", wr_cyc, 4, 3, 4, 5, 7, 0);

    // Six A words, no reads: fill stalls at 4; one read frees the fifth word
    pulse_reset("rst1");
    a_q.delete(); b_q.delete();
    load_a(6, 36'h1_2345_0000);
    rd_mask[11] = 1'b1;
    run(15);
    end_scen("s2");
    check_cycles("s2_a_acc", a_acc_cyc, 5, 2, 3, 4, 5, 12);
    check_cycles("s2_wr", wr_cyc, 5, 3, 4, 5, 6, 13);
    check_val("s2_full_busy", 64'(a_busy_log[10]), 64'd1);
    check_val("s2_rd_cycle_busy", 64'(a_busy_log[11]), 64'd1);
    check_val("s2_after_rd_busy", 64'(a_busy_log[12]), 64'd0);
    check_val("s2_refull_busy", 64'(a_busy_log[13]), 64'd1);

    // A packet with stb gaps while B waits: no preemption mid-packet
    pulse_reset("rst2");
    a_q.delete(); b_q.delete();
    load_a(4, 36'h0_CAFE_0000);
    b_q.push_back(36'hF_FFFF_0001);
    a_gap_mask[3] = 1'b1; a_gap_mask[4] = 1'b1; a_gap_mask[6] = 1'b1;
    rd_mask[6] = 1'b1;
    run(12);
    end_scen("s3");
    check_cycles("s3_a_acc", a_acc_cyc, 4, 2, 5, 7, 8, 0);
    check_cycles("s3_b_acc", b_acc_cyc, 1, 10, 0, 0, 0, 0);
    for (int c = 1; c <= 9; c++)
      check_val($sformatf("s3_b_busy_c%0d", c), 64'(b_busy_log[c]), 64'd1);

    // Read with zero occupancy: sticky error, count stays at zero
    pulse_reset("rst3");
    a_q.delete(); b_q.delete();
    load_a(5, 36'h5_0000_0100);
    rd_mask[1] = 1'b1;
    run(8);
    end_scen("s4");
    check_val("s4_err_before", 64'(err_log[1]), 64'd0);
    for (int c = 2; c <= 8; c++)
      check_val($sformatf("s4_err_c%0d", c), 64'(err_log[c]), 64'd1);
    check_cycles("s4_a_acc", a_acc_cyc, 4, 2, 3, 4, 5, 0);

    // Reset mid-packet after word 2 of 4: grant abandoned, rest re-arbitrated
    pulse_reset("rst4");
    a_q.delete(); b_q.delete();
    load_a(4, 36'h7_0000_0700);
    run(3);
    @(negedge i_clk);
    #2;
    check_cycles("s5_pre_a_acc", a_acc_cyc, 2, 2, 3, 0, 0, 0);
    pulse_reset("rst_mid");
    run(6);
    end_scen("s5");
    check_val("s5_idle_busy", 64'(a_busy_log[1]), 64'd1);
    check_cycles("s5_a_acc", a_acc_cyc, 2, 2, 3, 0, 0, 0);
    check_cycles("s5_wr", wr_cyc, 2, 3, 4, 0, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
endmodule
